// File: rtl/psum_buffer.sv
// -----------------------------------------------------------------------------
// psum_buffer
// Register-based H x W tile of signed partial-sum accumulators. Stores are
// row-major (entry = row*W + col). Each accepted input beat loads or
// saturating-adds LANES consecutive entries starting at addr. On command the
// tile is swept clear, or streamed out LANES entries per beat, optionally
// zeroing each group as it is read.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   ce             clock enable; low freezes every register and handshake
//   in_valid/in_ready, addr, load, in_data   input beat
//   start_clear    pulse: sweep-zero the tile
//   start_drain    pulse: stream the tile out; drain_clear sampled alongside
//   out_valid/out_ready, out_data, out_last  output stream
//   busy           FSM is not in ACCUM
//   sat_flag       sticky saturation indicator (cleared by reset or CLEAR)
//   dbg_state      FSM state (0 ACCUM, 1 CLEAR, 2 DRAIN)
//
// Handshakes: a beat transfers on the rising edge where valid && ready are
// both high. valid never depends on ready, and out_data is held stable while
// out_valid && !out_ready.
// -----------------------------------------------------------------------------
module psum_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int ACC_WIDTH  = 28,
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int LANES      = 4,
  parameter int AW         = $clog2(H * W)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [AW-1:0]                 addr,
  input  logic                          load,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          start_clear,
  input  logic                          start_drain,
  input  logic                          drain_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*ACC_WIDTH-1:0]    out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          sat_flag,
  output logic [1:0]                    dbg_state
);

  localparam int DEPTH = H * W;
  localparam int NGRP  = (DEPTH + LANES - 1) / LANES;
  localparam int PW    = (NGRP > 1) ? $clog2(NGRP) : 1;
  // Wide enough for addr+LANES-1 and NGRP*LANES without wrapping.
  localparam int XW    = AW + $clog2(LANES) + 1;

  localparam logic [XW-1:0]        DEPTH_X  = XW'(DEPTH);
  localparam logic [PW-1:0]        LAST_GRP = PW'(NGRP - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ACC_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        ptr_q;
  logic                 dclr_q;   // drain_clear latched with start_drain

  // Per-lane write path (input beat) and read/sweep path (pointer group).
  logic [XW-1:0]        wr_x   [LANES];
  logic [AW-1:0]        wr_idx [LANES];
  logic [ACC_WIDTH:0]   ext_x  [LANES];
  logic [ACC_WIDTH:0]   sum_x  [LANES];
  logic [ACC_WIDTH-1:0] wr_val [LANES];
  logic [LANES-1:0]     wr_ok;
  logic [LANES-1:0]     lane_sat;
  logic [XW-1:0]        rd_x   [LANES];
  logic [AW-1:0]        rd_idx [LANES];
  logic [LANES-1:0]     rd_ok;

  logic last_grp;
  assign last_grp  = (ptr_q == LAST_GRP);
  assign in_ready  = ce && (state_q == ACCUM);
  assign out_valid = ce && (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && last_grp;
  assign busy      = (state_q != ACCUM);
  assign dbg_state = state_q;

  always_comb begin
    wr_ok    = '0;
    lane_sat = '0;
    rd_ok    = '0;
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_x[k]   = XW'(addr) + XW'(k);
      wr_ok[k]  = (wr_x[k] < DEPTH_X);
      wr_idx[k] = wr_ok[k] ? wr_x[k][AW-1:0] : '0;
      ext_x[k]  = {{(ACC_WIDTH+1-DATA_WIDTH){in_data[k*DATA_WIDTH + DATA_WIDTH-1]}},
                   in_data[k*DATA_WIDTH +: DATA_WIDTH]};
      // One guard bit: overflow shows up as the top two bits disagreeing.
      sum_x[k]  = {mem[wr_idx[k]][ACC_WIDTH-1], mem[wr_idx[k]]} + ext_x[k];
      if (load) begin
        wr_val[k] = ext_x[k][ACC_WIDTH-1:0];
      end else if (sum_x[k][ACC_WIDTH] != sum_x[k][ACC_WIDTH-1]) begin
        wr_val[k]   = sum_x[k][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        lane_sat[k] = wr_ok[k];
      end else begin
        wr_val[k] = sum_x[k][ACC_WIDTH-1:0];
      end

      rd_x[k]   = XW'(ptr_q) * XW'(LANES) + XW'(k);
      rd_ok[k]  = (rd_x[k] < DEPTH_X);
      rd_idx[k] = rd_ok[k] ? rd_x[k][AW-1:0] : '0;
      out_data[k*ACC_WIDTH +: ACC_WIDTH] = rd_ok[k] ? mem[rd_idx[k]] : '0;
    end
  end

  // Next-state logic; CLEAR has priority over DRAIN.
  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        ACCUM: begin
          if (start_clear)      state_d = CLEAR;
          else if (start_drain) state_d = DRAIN;
        end
        CLEAR: if (last_grp)              state_d = ACCUM;
        DRAIN: if (out_ready && last_grp) state_d = ACCUM;
        default:                          state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr_q    <= '0;
      dclr_q   <= 1'b0;
      sat_flag <= 1'b0;
    end else if (ce) begin
      case (state_q)
        ACCUM: begin
          // A beat coinciding with a start pulse lands before the state change.
          if (in_valid) begin
            for (int k = 0; k < LANES; k++)
              if (wr_ok[k]) mem[wr_idx[k]] <= wr_val[k];
            if (|lane_sat) sat_flag <= 1'b1;
          end
          if (start_drain && !start_clear) dclr_q <= drain_clear;
        end
        CLEAR: begin
          for (int k = 0; k < LANES; k++)
            if (rd_ok[k]) mem[rd_idx[k]] <= '0;
          sat_flag <= 1'b0;
          ptr_q    <= last_grp ? '0 : ptr_q + 1'b1;
        end
        DRAIN: begin
          if (out_ready) begin
            if (dclr_q)
              for (int k = 0; k < LANES; k++)
                if (rd_ok[k]) mem[rd_idx[k]] <= '0;
            ptr_q <= last_grp ? '0 : ptr_q + 1'b1;
          end
        end
        default: ptr_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_buffer.sv
`timescale 1ns/1ps
module tb_psum_buffer;

  localparam int DW    = 24;
  localparam int ACC   = 28;
  localparam int H     = 12;
  localparam int W     = 11;
  localparam int LANES = 4;
  localparam int DEPTH = H * W;
  localparam int NGRP  = (DEPTH + LANES - 1) / LANES;
  localparam int AW    = $clog2(DEPTH);
  localparam longint ACC_MAX = (longint'(1) << (ACC - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC - 1));

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic load = 1'b0;
  logic start_clear = 1'b0;
  logic start_drain = 1'b0;
  logic drain_clear = 1'b0;
  logic out_ready = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LANES*DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, sat_flag;
  logic [LANES*ACC-1:0] out_data;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  psum_buffer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .H(H), .W(W), .LANES(LANES), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .load(load),
    .in_data(in_data), .start_clear(start_clear), .start_drain(start_drain),
    .drain_clear(drain_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .sat_flag(sat_flag), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  longint model [DEPTH];
  logic [LANES*ACC-1:0] exp_q [$];
  logic [ACC-1:0] got [DEPTH];

  function automatic logic [ACC-1:0] acc(input longint v);
    return v[ACC-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LANES*ACC-1:0] obs,
                       input logic [LANES*ACC-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input int a, input bit ld, input int l0, input int l1,
                      input int l2, input int l3);
    int lv [LANES];
    longint s;
    lv = '{l0, l1, l2, l3};
    in_valid = 1'b1;
    addr = AW'(a);
    load = ld;
    for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = DW'(lv[k]);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (a + k < DEPTH) begin
        if (ld) begin
          model[a+k] = lv[k];
        end else begin
          s = model[a+k] + lv[k];
          if (s > ACC_MAX) s = ACC_MAX;
          if (s < ACC_MIN) s = ACC_MIN;
          model[a+k] = s;
        end
      end
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  // Streams the whole tile, checking each accepted group against the model.
  task automatic drain(input bit clr, input bit toggle);
    logic [LANES*ACC-1:0] v, held;
    int beats, cyc;
    bit stalled;
    beats = 0; cyc = 0; stalled = 1'b0; held = '0;
    for (int g = 0; g < NGRP; g++) begin
      v = '0;
      for (int k = 0; k < LANES; k++)
        if (g*LANES + k < DEPTH) v[k*ACC +: ACC] = acc(model[g*LANES + k]);
      exp_q.push_back(v);
    end
    if (clr) zero_model();
    start_drain = 1'b1;
    drain_clear = clr;
    tick();
    start_drain = 1'b0;
    drain_clear = 1'b0;
    while (beats < NGRP && cyc < 400) begin
      out_ready = !toggle || (cyc % 2 == 1);
      check("drain_valid", out_valid, 1'b1);
      if (stalled) check("stall_hold", out_data, held);
      if (out_ready && out_valid) begin
        v = exp_q.pop_front();
        check($sformatf("drain_grp%0d", beats), out_data, v);
        check("out_last", out_last, beats == NGRP - 1);
        for (int k = 0; k < LANES; k++)
          if (beats*LANES + k < DEPTH) got[beats*LANES + k] = out_data[k*ACC +: ACC];
        beats++;
        stalled = 1'b0;
      end else begin
        held = out_data;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    exp_q.delete();
    check("drain_beats", beats, NGRP);
    check("drain_idle", busy, 1'b0);
  endtask

  // Counts cycles from a sampled start_clear until in_ready returns.
  task automatic wait_clear(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (!in_ready && n < 100) begin
      saw_valid |= out_valid;
      tick();
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bit sv;
    zero_model();

    // Reset state
    ce = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);

    // Empty tile drains as zeros, out_last on beat 33 only
    drain(1'b0, 1'b0);

    // Accumulate, accumulate again, then load
    beat(5, 1'b0, 1, -2, 3, -4);
    beat(5, 1'b0, 1, -2, 3, -4);
    drain(1'b0, 1'b0);
    check("acc_e5", got[5], acc(2));
    check("acc_e6", got[6], acc(-4));
    check("acc_e7", got[7], acc(6));
    check("acc_e8", got[8], acc(-8));
    beat(5, 1'b1, 7, 7, 7, 7);
    drain(1'b0, 1'b0);
    check("load_e5", got[5], acc(7));
    check("load_e8", got[8], acc(7));

    // Positive saturation on the 17th beat
    beat(0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) beat(0, 1'b0, 8388607, 0, 0, 0);
    check("sat_pos_16", sat_flag, 1'b0);
    beat(0, 1'b0, 8388607, 0, 0, 0);
    check("sat_pos_17", sat_flag, 1'b1);
    drain(1'b0, 1'b0);
    check("sat_pos_val", got[0], acc(134217727));

    // Swept clear: 33 cycles, clears sat_flag
    start_clear = 1'b1;
    tick();
    start_clear = 1'b0;
    check("clr_busy", busy, 1'b1);
    wait_clear(n, sv);
    zero_model();
    check("clr_cycles", n, 33);
    check("clr_sat", sat_flag, 1'b0);

    // Negative saturation: 16 beats land exactly on the minimum
    for (int i = 0; i < 16; i++) beat(0, 1'b0, -8388608, 0, 0, 0);
    check("sat_neg_16", sat_flag, 1'b0);
    beat(0, 1'b0, -8388608, 0, 0, 0);
    check("sat_neg_17", sat_flag, 1'b1);
    drain(1'b0, 1'b0);
    check("sat_neg_val", got[0], acc(-134217728));

    // Top-edge beats: lanes past the tile dropped, addr beyond tile ignored
    beat(130, 1'b0, 1, 1, 1, 1);
    beat(140, 1'b0, 5, 5, 5, 5);
    drain(1'b0, 1'b0);
    check("edge_e128", got[128], acc(0));
    check("edge_e129", got[129], acc(0));
    check("edge_e130", got[130], acc(1));
    check("edge_e131", got[131], acc(1));

    // Drain-with-clear under stalls, then the tile reads back as zeros
    drain(1'b1, 1'b1);
    drain(1'b0, 1'b0);
    check("dclr_e0", got[0], acc(0));

    // Non-clearing drain leaves data for an identical second pass
    beat(20, 1'b0, 3, -4, 5, -6);
    beat(20, 1'b0, 3, -4, 5, -6);
    drain(1'b0, 1'b0);
    drain(1'b0, 1'b0);
    check("keep_e23", got[23], acc(-12));

    // ce low: no handshake, no start, no write
    ce = 1'b0;
    in_valid = 1'b1; addr = AW'(20); load = 1'b1; in_data = '1;
    start_drain = 1'b1;
    #1;
    check("ce_in_ready", in_ready, 1'b0);
    check("ce_out_valid", out_valid, 1'b0);
    tick();
    check("ce_state", dbg_state, 2'd0);
    in_valid = 1'b0; start_drain = 1'b0; load = 1'b0;
    ce = 1'b1;
    drain(1'b0, 1'b0);

    // Simultaneous start pulses: CLEAR wins, no output beats
    beat(0, 1'b0, -8388608, 0, 0, 0);
    for (int i = 0; i < 16; i++) beat(0, 1'b0, -8388608, 0, 0, 0);
    check("both_pre_sat", sat_flag, 1'b1);
    start_clear = 1'b1;
    start_drain = 1'b1;
    out_ready = 1'b1;
    tick();
    start_clear = 1'b0;
    start_drain = 1'b0;
    check("both_state", dbg_state, 2'd1);
    wait_clear(n, sv);
    out_ready = 1'b0;
    zero_model();
    check("both_cycles", n, 33);
    check("both_no_valid", sv, 1'b0);
    check("both_sat", sat_flag, 1'b0);

    // Reset in the middle of a drain
    beat(0, 1'b1, 9, 9, 9, 9);
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    zero_model();
    drain(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
